// File: rtl/codel_drop_ctrl_pkg.sv
// Shared types, widths and the inverse-sqrt table generator for the CoDel control-law engine.
// Optional feature macro (used by the interface and top): CODEL_DROP_STATS_EN.
package codel_drop_ctrl_pkg;

  localparam int unsigned TIME_W        = 32;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned LUT_DEPTH     = 64;
  localparam int unsigned INV_SQRT_FRAC = 16;
  localparam int unsigned CALC_CYCLES   = 16;
  localparam int unsigned STEP_W        = $clog2(CALC_CYCLES);
  localparam int unsigned PROD_W        = TIME_W + INV_SQRT_FRAC;
  localparam int unsigned STATS_W       = 32;

  typedef logic [TIME_W-1:0]        time_ctr_t;
  typedef logic [CNT_W-1:0]         drop_count_t;
  typedef logic [INV_SQRT_FRAC-1:0] inv_sqrt_t;
  typedef logic [1:0]               state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_DROPPING = 2'd1;
  localparam state_t ST_CALC     = 2'd2;

  // round(65536/sqrt(n)) = largest k with (2k-1)^2 * n <= 2^34; clamped to 16 bits (n=1 -> 65535)
  function automatic inv_sqrt_t inv_sqrt_entry(input int unsigned n);
    longint unsigned k;
    longint unsigned trial;
    longint unsigned odd;
    if (n == 0) return '1;
    k = 64'd0;
    for (int b = INV_SQRT_FRAC; b >= 0; b--) begin
      trial = k | (64'd1 << b);
      odd   = (trial << 1) - 64'd1;
      if ((odd * odd * 64'(n)) <= (64'd1 << 34)) k = trial;
    end
    if (k > 64'hFFFF) return '1;
    return INV_SQRT_FRAC'(k);
  endfunction

endpackage

// File: rtl/codel_drop_ctrl_if.sv
// Dequeue-stage <-> control-law engine handshake and status bundle.
// Optional feature macro: CODEL_DROP_STATS_EN adds o__drop_total.
interface codel_drop_ctrl_if;
  import codel_drop_ctrl_pkg::*;

  logic        i__deq_valid;
  logic        o__ready;
  logic        i__okay_to_drop;
  time_ctr_t   i__time_counter;
  time_ctr_t   i__interval;
  logic        o__drop;
  logic        o__dropping;
  drop_count_t o__count;
  time_ctr_t   o__drop_next;
`ifdef CODEL_DROP_STATS_EN
  logic [STATS_W-1:0] o__drop_total;
`endif

`ifdef CODEL_DROP_STATS_EN
  modport master (
    output i__deq_valid, i__okay_to_drop, i__time_counter, i__interval,
    input  o__ready, o__drop, o__dropping, o__count, o__drop_next, o__drop_total
  );
  modport slave (
    input  i__deq_valid, i__okay_to_drop, i__time_counter, i__interval,
    output o__ready, o__drop, o__dropping, o__count, o__drop_next, o__drop_total
  );
`else
  modport master (
    output i__deq_valid, i__okay_to_drop, i__time_counter, i__interval,
    input  o__ready, o__drop, o__dropping, o__count, o__drop_next
  );
  modport slave (
    input  i__deq_valid, i__okay_to_drop, i__time_counter, i__interval,
    output o__ready, o__drop, o__dropping, o__count, o__drop_next
  );
`endif

endinterface

// File: rtl/codel_drop_ctrl_inv_sqrt.sv
// Combinational 1/sqrt(count) lookup in Q0.16; counts beyond the table use the last entry.
module codel_drop_ctrl_inv_sqrt
  import codel_drop_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = LUT_DEPTH
) (
  input  drop_count_t count,
  output inv_sqrt_t   inv
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  inv_sqrt_t        table_c [DEPTH+1];
  logic [IDX_W-1:0] idx;

  // Table contents are elaboration-time constants
  for (genvar g = 0; g <= DEPTH; g++) begin : g_tab
    localparam inv_sqrt_t ENTRY = inv_sqrt_entry(g);
    assign table_c[g] = ENTRY;
  end

  // Clamp the index to the last entry, then look up
  always_comb begin
    idx = (count > drop_count_t'(DEPTH)) ? IDX_W'(DEPTH) : IDX_W'(count);
    inv = table_c[idx];
  end

endmodule

// File: rtl/codel_drop_ctrl.sv
// CoDel dequeue control-law engine: dropping state, drop count and next drop time,
// with drop_next = base + interval/sqrt(count) from a 16-cycle serial shift-add multiply.
// Optional feature macro: CODEL_DROP_STATS_EN adds a saturating o__drop_total counter.
module codel_drop_ctrl
  import codel_drop_ctrl_pkg::*;
(
  input logic              clk,
  input logic              reset,
  codel_drop_ctrl_if.slave bus
);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                dropping_q, dropping_d;
  drop_count_t         count_q, count_d;
  time_ctr_t           drop_next_q, drop_next_d;
  time_ctr_t           base_q, base_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   acc_sum;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                drop_c;
  logic                start_calc;
  logic                accept;
  inv_sqrt_t           inv_c;
  time_ctr_t           gap;
  logic [TIME_W+3:0]   gap_ext;
  logic [TIME_W+3:0]   thresh;

  // Multiplier bits come from the already-updated count held during CALC
  codel_drop_ctrl_inv_sqrt #(.DEPTH(LUT_DEPTH)) u_inv_sqrt (
    .count (count_q),
    .inv   (inv_c)
  );

  assign accept  = bus.i__deq_valid & ready_q;
  assign gap     = bus.i__time_counter - drop_next_q;
  assign gap_ext = (TIME_W + 4)'(gap);
  assign thresh  = {bus.i__interval, 4'b0000};

  // Next-state, datapath updates and the combinational drop decision
  always_comb begin
    state_d     = state_q;
    dropping_d  = dropping_q;
    count_d     = count_q;
    drop_next_d = drop_next_q;
    base_d      = base_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    step_d      = step_q;
    drop_c      = 1'b0;
    start_calc  = 1'b0;
    acc_sum     = acc_q + (inv_c[step_q] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (accept && bus.i__okay_to_drop) begin
          drop_c     = 1'b1;
          dropping_d = 1'b1;
          // Re-entering soon after the last episode resumes near the old rate
          if ((gap_ext < thresh) && (count_q > drop_count_t'(2))) begin
            count_d = count_q - drop_count_t'(2);
          end else begin
            count_d = drop_count_t'(1);
          end
          base_d     = bus.i__time_counter;
          start_calc = 1'b1;
          state_d    = ST_CALC;
        end
      end
      ST_DROPPING: begin
        if (accept) begin
          if (!bus.i__okay_to_drop) begin
            dropping_d = 1'b0;
            state_d    = ST_IDLE;
          end else if (bus.i__time_counter >= drop_next_q) begin
            drop_c     = 1'b1;
            count_d    = (count_q == '1) ? count_q : count_q + drop_count_t'(1);
            base_d     = drop_next_q;
            start_calc = 1'b1;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        step_d  = step_q + STEP_W'(1);
        if (step_q == STEP_W'(CALC_CYCLES - 1)) begin
          drop_next_d = base_q + TIME_W'(acc_sum >> INV_SQRT_FRAC);
          state_d     = ST_DROPPING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_calc) begin
      acc_d   = '0;
      mcand_d = PROD_W'(bus.i__interval);
      step_d  = '0;
    end

    ready_d = (state_d != ST_CALC);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      dropping_q  <= 1'b0;
      count_q     <= '0;
      drop_next_q <= '0;
      base_q      <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      dropping_q  <= dropping_d;
      count_q     <= count_d;
      drop_next_q <= drop_next_d;
      base_q      <= base_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
    end
  end

  assign bus.o__ready     = ready_q;
  assign bus.o__drop      = drop_c;
  assign bus.o__dropping  = dropping_q;
  assign bus.o__count     = count_q;
  assign bus.o__drop_next = drop_next_q;

`ifdef CODEL_DROP_STATS_EN
  logic [STATS_W-1:0] drop_total_q;

  // Saturating count of dropped packets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_total_q <= '0;
    end else if (drop_c && (drop_total_q != '1)) begin
      drop_total_q <= drop_total_q + STATS_W'(1);
    end
  end

  assign bus.o__drop_total = drop_total_q;
`endif

endmodule

// File: tb/tb_codel_drop_ctrl.sv
// Directed bench for codel_drop_ctrl; expected times are hand-computed from
// round(65536/sqrt(n)): n=1..5 -> 65535, 46341, 37837, 32768, 29309.
module tb_codel_drop_ctrl;
  import codel_drop_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  codel_drop_ctrl_if bus ();

  codel_drop_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one packet; drop is checked before the edge, then the accepting edge is taken
  task automatic present(input logic okay, input logic [31:0] now, input logic exp_drop,
                         input string tag);
    @(negedge clk);
    bus.i__deq_valid     = 1'b1;
    bus.i__okay_to_drop  = okay;
    bus.i__time_counter  = now;
    #1;
    check({tag, "_drop"}, 64'(bus.o__drop), 64'(exp_drop));
    @(posedge clk);
    #1;
    bus.i__deq_valid = 1'b0;
  endtask

  // Called at accept edge + 1: ready low through edge 15, high with new drop_next at edge 16
  task automatic finish_calc(input logic [31:0] exp_dn, input string tag);
    check({tag, "_ready_lo0"}, 64'(bus.o__ready), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    check({tag, "_ready_lo15"}, 64'(bus.o__ready), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_ready_hi"}, 64'(bus.o__ready), 64'd1);
    check({tag, "_drop_next"}, 64'(bus.o__drop_next), 64'(exp_dn));
    check({tag, "_dropping"}, 64'(bus.o__dropping), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.i__deq_valid    = 1'b0;
    bus.i__okay_to_drop = 1'b0;
    bus.i__time_counter = '0;
    bus.i__interval     = 32'd100;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.o__ready), 64'd1);
    check("rst_dropping", 64'(bus.o__dropping), 64'd0);
    check("rst_count", 64'(bus.o__count), 64'd0);
    check("rst_drop_next", 64'(bus.o__drop_next), 64'd0);
    check("rst_drop", 64'(bus.o__drop), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Entry from IDLE: count=1, drop_next = 1000 + 99
    present(1'b1, 32'd1000, 1'b1, "entry");
    check("entry_count", 64'(bus.o__count), 64'd1);
    check("entry_dropping", 64'(bus.o__dropping), 64'd1);
    finish_calc(32'd1099, "entry");

    // Early packet is forwarded
    present(1'b1, 32'd1050, 1'b0, "early");
    check("early_count", 64'(bus.o__count), 64'd1);
    check("early_ready", 64'(bus.o__ready), 64'd1);

    // Scheduled drops at now == drop_next
    present(1'b1, 32'd1099, 1'b1, "sched2");
    check("sched2_count", 64'(bus.o__count), 64'd2);
    finish_calc(32'd1169, "sched2");
    present(1'b1, 32'd1169, 1'b1, "sched3");
    check("sched3_count", 64'(bus.o__count), 64'd3);
    finish_calc(32'd1226, "sched3");
    present(1'b1, 32'd1226, 1'b1, "sched4");
    check("sched4_count", 64'(bus.o__count), 64'd4);
    finish_calc(32'd1276, "sched4");
    present(1'b1, 32'd1276, 1'b1, "sched5");
    check("sched5_count", 64'(bus.o__count), 64'd5);
    finish_calc(32'd1320, "sched5");

    // Exit: count and drop_next held
    present(1'b0, 32'd1330, 1'b0, "exit");
    check("exit_dropping", 64'(bus.o__dropping), 64'd0);
    check("exit_count", 64'(bus.o__count), 64'd5);
    check("exit_drop_next", 64'(bus.o__drop_next), 64'd1320);
    check("exit_ready", 64'(bus.o__ready), 64'd1);

    // IDLE with okay=0 stays idle
    present(1'b0, 32'd1340, 1'b0, "idle_ok0");
    check("idle_ok0_dropping", 64'(bus.o__dropping), 64'd0);

    // Re-entry near the last episode: count 5 -> 3, drop_next = 1400 + 57; stall during CALC
    present(1'b1, 32'd1400, 1'b1, "reentry");
    check("reentry_count", 64'(bus.o__count), 64'd3);
    for (int i = 0; i < CALC_CYCLES; i++) begin
      @(negedge clk);
      bus.i__deq_valid    = 1'b1;
      bus.i__okay_to_drop = 1'b1;
      bus.i__time_counter = 32'd2000;
      #1;
      check($sformatf("stall%0d_drop", i), 64'(bus.o__drop), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.i__deq_valid = 1'b0;
    check("stall_ready_hi", 64'(bus.o__ready), 64'd1);
    check("stall_count", 64'(bus.o__count), 64'd3);
    check("reentry_drop_next", 64'(bus.o__drop_next), 64'd1457);

    present(1'b0, 32'd1460, 1'b0, "exit2");
    check("exit2_count", 64'(bus.o__count), 64'd3);

    // Gap exactly 16*interval is not "recent": count restarts at 1
    present(1'b1, 32'd3057, 1'b1, "far");
    check("far_count", 64'(bus.o__count), 64'd1);
    finish_calc(32'd3156, "far");

    present(1'b0, 32'd3160, 1'b0, "exit3");

    // Recent but count <= 2: count restarts at 1; reset pulsed in the middle of CALC
    present(1'b1, 32'd3200, 1'b1, "lowcnt");
    check("lowcnt_count", 64'(bus.o__count), 64'd1);
    check("lowcnt_ready", 64'(bus.o__ready), 64'd0);
`ifdef CODEL_DROP_STATS_EN
    check("stats_total8", 64'(bus.o__drop_total), 64'd8);
`endif
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", 64'(bus.o__ready), 64'd1);
    check("midrst_dropping", 64'(bus.o__dropping), 64'd0);
    check("midrst_count", 64'(bus.o__count), 64'd0);
    check("midrst_drop_next", 64'(bus.o__drop_next), 64'd0);
    check("midrst_drop", 64'(bus.o__drop), 64'd0);
`ifdef CODEL_DROP_STATS_EN
    check("stats_rst", 64'(bus.o__drop_total), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Fresh entry after reset behaves like the first one
    present(1'b1, 32'd5000, 1'b1, "post_rst");
    check("post_rst_count", 64'(bus.o__count), 64'd1);
    finish_calc(32'd5099, "post_rst");

`ifdef CODEL_DROP_STATS_EN
    check("stats_one", 64'(bus.o__drop_total), 64'd1);
    @(negedge clk);
    force dut.drop_total_q = '1;
    #1;
    release dut.drop_total_q;
    present(1'b1, 32'd5099, 1'b1, "sat");
    check("stats_sat", 64'(bus.o__drop_total), 64'hFFFF_FFFF);
    finish_calc(32'd5169, "sat");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
